// File: rtl/small_alu_if.sv
// small_alu_if -- operand/result bundle for small_alu.
//
// Signals (WIDTH-bit operands and result, two's complement):
//   in_valid   master -> slave  qualifies add_sub/dataa/datab this cycle
//   add_sub    master -> slave  1 = add, 0 = subtract
//   dataa      master -> slave  operand A
//   datab      master -> slave  operand B
//   result     slave -> master  registered result
//   out_valid  slave -> master  result/overflow/carry updated this cycle
//   overflow   slave -> master  signed overflow of the registered operation
//   carry      slave -> master  carry-out (add) / no-borrow (subtract)
interface small_alu_if #(
   parameter int unsigned WIDTH = 9
);
   logic             in_valid;
   logic             add_sub;
   logic [WIDTH-1:0] dataa;
   logic [WIDTH-1:0] datab;
   logic [WIDTH-1:0] result;
   logic             out_valid;
   logic             overflow;
   logic             carry;

   modport master (
      output in_valid, add_sub, dataa, datab,
      input  result, out_valid, overflow, carry
   );

   modport slave (
      input  in_valid, add_sub, dataa, datab,
      output result, out_valid, overflow, carry
   );
endinterface

// File: rtl/small_alu.sv
// small_alu -- registered signed add/subtract with overflow and carry flags.
//
// One-cycle latency: an operation sampled with in_valid=1 on a rising edge of
// clk appears on result/overflow/carry with out_valid=1 right after that edge.
// When in_valid=0 the result and flags hold; out_valid drops to 0.
//
// Ports:
//   clk     sole clock, rising edge
//   rst     asynchronous active-high reset; clears all outputs
//   bus_io  small_alu_if.slave (in_valid, add_sub, dataa, datab ->
//           result, out_valid, overflow, carry)
//
// Build option: define SMALL_ALU_SAT_EN to saturate result on signed overflow
// (to the most positive / most negative value); otherwise result wraps.
module small_alu #(
   parameter int unsigned WIDTH = 9
) (
   input logic           clk,
   input logic           rst,
   small_alu_if.slave    bus_io
);

   logic [WIDTH-1:0] b_eff;
   logic             cin;
   logic [WIDTH:0]   usum;
   logic [WIDTH-1:0] sum_wrap;
   logic             ovf;
   logic [WIDTH-1:0] res_d;

   logic [WIDTH-1:0] result_q;
   logic             out_valid_q;
   logic             overflow_q;
   logic             carry_q;

   // Subtract is a + ~b + 1, so a single adder serves both operations.
   always_comb begin
      b_eff    = bus_io.add_sub ? bus_io.datab : ~bus_io.datab;
      cin      = ~bus_io.add_sub;
      usum     = {1'b0, bus_io.dataa} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      sum_wrap = usum[WIDTH-1:0];
      // Operands of equal sign producing a result of the opposite sign.
      ovf      = (bus_io.dataa[WIDTH-1] == b_eff[WIDTH-1]) &&
                 (sum_wrap[WIDTH-1] != bus_io.dataa[WIDTH-1]);
   end

`ifdef SMALL_ALU_SAT_EN
   // On overflow the true result has the sign of operand A.
   always_comb begin
      res_d = sum_wrap;
      if (ovf) begin
         res_d = bus_io.dataa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   always_comb begin
      res_d = sum_wrap;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         carry_q     <= 1'b0;
      end else begin
         out_valid_q <= bus_io.in_valid;
         if (bus_io.in_valid) begin
            result_q   <= res_d;
            overflow_q <= ovf;
            carry_q    <= usum[WIDTH];
         end
      end
   end

   assign bus_io.result    = result_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.overflow  = overflow_q;
   assign bus_io.carry     = carry_q;

endmodule

// File: tb/tb_small_alu.sv
// tb_small_alu -- directed vector table, hold/reset sequences and a randomized
// run against an integer-arithmetic reference model.
module tb_small_alu;

   localparam int unsigned W = 9;

   logic clk;
   logic rst;

   small_alu_if #(.WIDTH(W)) bus ();

   small_alu #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic         add_sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ov;
      logic         cy;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         ov;
      logic         cy;
   } exp_t;

   // Exact integer arithmetic, then derive the flags from their definitions.
   function automatic exp_t model(input logic as, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      exp_t   e;
      longint sa, sb, ua, ub, exact, maxv, minv;
      logic [63:0] bits;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      ua    = longint'(a);
      ub    = longint'(b);
      exact = as ? sa + sb : sa - sb;
      maxv  = (longint'(1) <<< (W - 1)) - 1;
      minv  = -(longint'(1) <<< (W - 1));
      e.ov  = (exact > maxv) || (exact < minv);
      bits  = exact;
`ifdef SMALL_ALU_SAT_EN
      if (exact > maxv) bits = maxv;
      else if (exact < minv) bits = minv;
`endif
      e.res = bits[W-1:0];
      e.cy  = as ? ((ua + ub) >= (longint'(1) <<< W)) : (ua >= ub);
      return e;
   endfunction

   task automatic check_all(input string name, input logic [W-1:0] r, input logic ov,
                            input logic cy, input logic v);
      check({name, ".result"}, 32'(bus.result), 32'(r));
      check({name, ".overflow"}, 32'(bus.overflow), 32'(ov));
      check({name, ".carry"}, 32'(bus.carry), 32'(cy));
      check({name, ".out_valid"}, 32'(bus.out_valid), 32'(v));
   endtask

   vec_t vecs[4];
   exp_t e_q;
   logic v_q;

   initial begin
      vecs[0] = '{1'b1, 9'h1FF, 9'h001, 9'h000, 1'b0, 1'b1};
`ifdef SMALL_ALU_SAT_EN
      vecs[1] = '{1'b1, 9'h1DF, 9'h119, 9'h100, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 9'h0FF, 9'h001, 9'h0FF, 1'b1, 1'b0};
`else
      vecs[1] = '{1'b1, 9'h1DF, 9'h119, 9'h0F8, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 9'h0FF, 9'h001, 9'h100, 1'b1, 1'b0};
`endif
      vecs[3] = '{1'b0, 9'h05F, 9'h079, 9'h1E6, 1'b0, 1'b0};

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.add_sub  = 1'b0;
      bus.dataa    = '0;
      bus.datab    = '0;
      #1;
      check_all("reset", '0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Table vectors applied back to back (full throughput).
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.add_sub  = vecs[i].add_sub;
         bus.dataa    = vecs[i].a;
         bus.datab    = vecs[i].b;
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].ov, vecs[i].cy, 1'b1);
      end

      // Hold with garbage on the operands.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.add_sub  = 1'b1;
         bus.dataa    = 9'h0FF;
         bus.datab    = 9'h0FF;
         @(posedge clk);
         #1;
         check_all($sformatf("hold%0d", i), 9'h1E6, 1'b0, 1'b0, 1'b0);
      end

      // Valid op, then asynchronous reset mid-cycle.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.add_sub  = 1'b1;
      bus.dataa    = 9'h1DF;
      bus.datab    = 9'h119;
      @(posedge clk);
      #1;
      check("pre_rst.out_valid", 32'(bus.out_valid), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check_all("async_rst", '0, 1'b0, 1'b0, 1'b0);

      // Op presented during reset is discarded.
      @(posedge clk);
      #1;
      check("in_rst.out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_all("post_rst_idle", '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.add_sub  = 1'b0;
      bus.dataa    = 9'h05F;
      bus.datab    = 9'h079;
      @(posedge clk);
      #1;
      check_all("first_after_rst", 9'h1E6, 1'b0, 1'b0, 1'b1);

      // Randomized run from a clean reset.
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst   = 1'b0;
      e_q   = '{'0, 1'b0, 1'b0};
      v_q   = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic         iv, as;
         logic [W-1:0] a, b;
         logic [W-1:0] corners [4];
         corners[0] = '0;
         corners[1] = {1'b0, {(W-1){1'b1}}};
         corners[2] = {1'b1, {(W-1){1'b0}}};
         corners[3] = '1;
         iv = ($urandom_range(0, 3) != 0);
         as = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
         @(negedge clk);
         bus.in_valid = iv;
         bus.add_sub  = as;
         bus.dataa    = a;
         bus.datab    = b;
         @(posedge clk);
         #1;
         if (iv) e_q = model(as, a, b);
         v_q = iv;
         check_all("rand", e_q.res, e_q.ov, e_q.cy, v_q);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/small_alu.md
SMALL_ALU -- requirements
Module: small_alu

Interface
REQ-001 Parameter: WIDTH, default 9, operand and result width in bits; the block SHALL support WIDTH 2..32.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  qualifies add_sub/dataa/datab in the current cycle.
REQ-005 Port: add_sub  input  1  operation select: 1 = add, 0 = subtract.
REQ-006 Port: dataa  input  WIDTH  signed two's-complement operand A.
REQ-007 Port: datab  input  WIDTH  signed two's-complement operand B.
REQ-008 Port: result  output  WIDTH  signed registered result.
REQ-009 Port: out_valid  output  1  result/overflow/carry hold a new operation this cycle.
REQ-010 Port: overflow  output  1  signed overflow of the registered operation.
REQ-011 Port: carry  output  1  unsigned carry-out (add) or no-borrow (subtract) of the registered operation.

Function
REQ-012 With add_sub=1, the block SHALL compute dataa + datab; with add_sub=0, dataa - datab (computed as dataa + ~datab + 1).
REQ-013 Latency SHALL be exactly one clock: inputs sampled with in_valid=1 at edge N appear on result/overflow/carry with out_valid=1 after edge N.
REQ-014 out_valid SHALL be 1 for exactly the cycle after each accepted operation and 0 otherwise; back-to-back in_valid SHALL yield back-to-back out_valid at full throughput.
REQ-015 When in_valid=0, result, overflow and carry SHALL hold their previous values.
REQ-016 Without saturation, result SHALL be the low WIDTH bits of the exact sum/difference (two's-complement wrap-around).
REQ-017 overflow SHALL be 1 when the exact signed result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], else 0.
REQ-018 carry SHALL be bit WIDTH of the (WIDTH+1)-bit unsigned sum of dataa and the effective B operand including carry-in.
REQ-019 The datapath SHALL be purely combinational up to a single output register stage; no other state exists.

Reset
REQ-020 While rst=1, result SHALL be 0, out_valid 0, overflow 0, carry 0, independent of clk.
REQ-021 An operation in flight when rst asserts SHALL be discarded; the first accepted operation after release SHALL produce out_valid one edge later.
REQ-022 rst deassertion SHALL be treated as synchronous to clk by the integrator; the block needs no internal synchronizer.

Configuration
REQ-023 Macro SMALL_ALU_SAT_EN: when defined, on overflow result SHALL saturate to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow); overflow and carry behave as in REQ-017/REQ-018.
REQ-024 When SMALL_ALU_SAT_EN is not defined, result SHALL wrap per REQ-016 and no saturation logic SHALL be present.

Verification
REQ-025 Add: dataa=0x1FF (-1), datab=0x001, add_sub=1 -> result=0x000, overflow=0, carry=1, out_valid one cycle later.
REQ-026 Add, negative overflow: dataa=0x1DF (-33), datab=0x119 (-231), add_sub=1 -> overflow=1, carry=1; result=0x0F8 without SMALL_ALU_SAT_EN, 0x100 (-256) with it.
REQ-027 Subtract: dataa=0x05F (95), datab=0x079 (121), add_sub=0 -> result=0x1E6 (-26), overflow=0, carry=0.
REQ-028 Positive overflow: dataa=0x0FF (255), datab=0x001, add_sub=1 -> overflow=1; result=0x100 wrapped, 0x0FF saturated.
REQ-029 Hold/reset: in_valid=0 after REQ-027 -> result stays 0x1E6, out_valid=0; assert rst mid-cycle -> all outputs 0 immediately without a clock edge.
